// File: rtl/alu_nbits_seq.sv
// Registered N-bit ALU: add/sub/NOR/shift finish in one cycle, multiply is a WIDTH-step shift-add.
// Result and flags are updated only on the edge that enters DONE, announced by a one-cycle pulse.
module alu_nbits_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [2:0]         sel,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] Y,
    output logic               overflow,
    output logic               zero,
    output logic               err
);

    localparam int unsigned YW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpMul = 3'b010;
    localparam logic [2:0] OpNor = 3'b011;
    localparam logic [2:0] OpShl = 3'b100;
    localparam logic [2:0] OpShr = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDone
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [YW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [YW-1:0]    r_acc;
    logic [CW-1:0]    r_count;
    logic [YW-1:0]    r_y;
    logic             r_ovf;
    logic             r_zero;
    logic             r_err;

    logic [YW-1:0]    w_a_ext;
    logic [YW-1:0]    w_b_ext;
    logic [YW-1:0]    w_sum;
    logic [YW-1:0]    w_diff;
    logic [WIDTH-1:0] w_nor;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    logic [YW-1:0]    w_op_y;
    logic             w_op_ovf;
    logic             w_op_err;
    logic [YW-1:0]    w_pp;
    logic [YW-1:0]    w_acc_next;
    logic             w_mul_last;

    assign w_a_ext = {{WIDTH{1'b0}}, A};
    assign w_b_ext = {{WIDTH{1'b0}}, B};
    assign w_sum   = w_a_ext + w_b_ext;
    // Subtracting zero-extended operands at 2*WIDTH yields the sign-extended difference.
    assign w_diff  = w_a_ext - w_b_ext;
    assign w_nor   = ~(A | B);
    assign w_shl   = {A[WIDTH-2:0], 1'b0};
    assign w_shr   = {1'b0, A[WIDTH-1:1]};

    // Single-cycle ops are evaluated straight from the inputs at the sampling edge.
    always_comb begin
        w_op_y   = '0;
        w_op_ovf = 1'b0;
        w_op_err = 1'b0;
        case (sel)
            OpAdd: begin
                w_op_y   = w_sum;
                w_op_ovf = w_sum[WIDTH];
            end
            OpSub: begin
                w_op_y   = w_diff;
                w_op_ovf = (A < B);
            end
            OpNor: begin
                w_op_y = YW'(w_nor);
            end
            OpShl: begin
                w_op_y   = YW'(w_shl);
                w_op_ovf = A[WIDTH-1];
            end
            OpShr: begin
                w_op_y   = YW'(w_shr);
                w_op_ovf = A[0];
            end
            OpMul: begin
                w_op_y = '0;
            end
            default: begin
                w_op_err = 1'b1;
            end
        endcase
    end

    assign w_pp       = r_mplier[r_count] ? (r_mcand << r_count) : '0;
    assign w_acc_next = r_acc + w_pp;
    assign w_mul_last = (r_count == CW'(WIDTH - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next = (sel == OpMul) ? StMul : StDone;
                end
            end
            StMul: begin
                if (w_mul_last) begin
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_y      <= '0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_mcand  <= w_a_ext;
                        r_mplier <= B;
                        r_acc    <= '0;
                        r_count  <= '0;
                        if (sel != OpMul) begin
                            r_y    <= w_op_y;
                            r_ovf  <= w_op_ovf;
                            r_zero <= (w_op_y == '0);
                            r_err  <= w_op_err;
                        end
                    end
                end
                StMul: begin
                    r_acc   <= w_acc_next;
                    r_count <= r_count + CW'(1);
                    if (w_mul_last) begin
                        r_y    <= w_acc_next;
                        r_ovf  <= |w_acc_next[YW-1:WIDTH];
                        r_zero <= (w_acc_next == '0);
                        r_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != StIdle);
    assign done     = (r_state == StDone);
    assign Y        = r_y;
    assign overflow = r_ovf;
    assign zero     = r_zero;
    assign err      = r_err;

endmodule
